// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and types for the EXE forwarding / hazard unit.
package fwd_hazard_unit_pkg;

  localparam int unsigned FWD_SEL_W = 2;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned PERF_W    = 32;
  localparam int unsigned REG_ZERO  = 0;

  localparam logic [FWD_SEL_W-1:0] FWD_SEL_RF  = 2'b00;
  localparam logic [FWD_SEL_W-1:0] FWD_SEL_WB  = 2'b01;
  localparam logic [FWD_SEL_W-1:0] FWD_SEL_MEM = 2'b10;

  typedef enum logic {
    IDLE    = 1'b0,
    LD_HOLD = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/fwd_hazard_unit_fwd_select.sv
// Per-channel EXE operand forwarding select; the younger MEM result beats WB.
module fwd_select
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_dst,
  input  logic                  wb_reg_write,
  output logic [FWD_SEL_W-1:0]  sel
);

  // Priority match: MEM, then WB, else register file; r0 never forwards.
  always_comb begin
    sel = FWD_SEL_RF;
    if (mem_reg_write && (mem_dst != REG_ADDR_W'(REG_ZERO)) && (mem_dst == src)) begin
      sel = FWD_SEL_MEM;
    end else if (wb_reg_write && (wb_dst != REG_ADDR_W'(REG_ZERO)) && (wb_dst == src)) begin
      sel = FWD_SEL_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EXE forwarding, load-use stall and multi-cycle scoreboard control.
// Optional macro FU_PERF_CNT_EN adds saturating stall-cycle / load-use counters.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned LOAD_STALL = 1
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]   I_FU_EXE_SRC,
  input  logic [REG_ADDR_W-1:0]           I_FU_EXE_regDst,
  input  logic                            I_FU_EXE_RegWrite,
  input  logic                            I_FU_EXE_MemRead,
  input  logic [REG_ADDR_W-1:0]           I_FU_MEM_regDst,
  input  logic                            I_FU_MEM_RegWrite,
  input  logic [REG_ADDR_W-1:0]           I_FU_WB_regDst,
  input  logic                            I_FU_WB_RegWrite,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]   I_FU_ID_SRC,
  input  logic [NUM_SRC-1:0]              I_FU_ID_SRC_VALID,
  input  logic [REG_ADDR_W-1:0]           I_FU_ID_regDst,
  input  logic                            I_FU_ID_RegWrite,
  input  logic                            I_FU_ID_IS_MC,
  input  logic                            I_FU_MC_ISSUE,
  input  logic [REG_ADDR_W-1:0]           I_FU_MC_regDst,
  input  logic                            I_FU_MC_DONE,
  input  logic [REG_ADDR_W-1:0]           I_FU_MC_DONE_regDst,
  output logic [FWD_SEL_W*NUM_SRC-1:0]    O_FU_FWD_SEL,
  output logic                            O_FU_STALL,
  output logic                            O_FU_BUBBLE,
  output logic                            O_FU_MC_BUSY
`ifdef FU_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]               O_FU_STALL_CYCLES,
  output logic [PERF_W-1:0]               O_FU_LU_EVENTS
`endif
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

  fsm_state_e          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [NUM_REGS-1:0] pend, pend_nxt;
  logic                lu, sb, hold, stall;

  // One forwarding selector per source channel.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_select (
      .src           (I_FU_EXE_SRC[k*REG_ADDR_W +: REG_ADDR_W]),
      .mem_dst       (I_FU_MEM_regDst),
      .mem_reg_write (I_FU_MEM_RegWrite),
      .wb_dst        (I_FU_WB_regDst),
      .wb_reg_write  (I_FU_WB_RegWrite),
      .sel           (O_FU_FWD_SEL[k*FWD_SEL_W +: FWD_SEL_W])
    );
  end

  // Load-use hazard: a valid ID source needs the load currently in EXE.
  always_comb begin
    lu = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (I_FU_ID_SRC_VALID[k] &&
          (I_FU_ID_SRC[k*REG_ADDR_W +: REG_ADDR_W] == I_FU_EXE_regDst)) begin
        lu = 1'b1;
      end
    end
    lu = lu && I_FU_EXE_MemRead && I_FU_EXE_RegWrite &&
         (I_FU_EXE_regDst != REG_ADDR_W'(REG_ZERO));
  end

  // Scoreboard hazard from registered pending bits: RAW, WAW and structural.
  always_comb begin
    sb = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (I_FU_ID_SRC_VALID[k] && pend[I_FU_ID_SRC[k*REG_ADDR_W +: REG_ADDR_W]]) begin
        sb = 1'b1;
      end
    end
    if (I_FU_ID_RegWrite && pend[I_FU_ID_regDst]) sb = 1'b1;
    if (I_FU_ID_IS_MC && O_FU_MC_BUSY)            sb = 1'b1;
  end

  // Stall FSM next-state and hold decision.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold      = 1'b0;
    case (state)
      IDLE: begin
        if (lu) begin
          hold = 1'b1;
          if (LOAD_STALL > 1) begin
            state_nxt = LD_HOLD;
            cnt_nxt   = CNT_W'(LOAD_STALL - 1);
          end
        end else if (sb) begin
          hold = 1'b1;
        end
      end
      LD_HOLD: begin
        hold    = 1'b1;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stall outputs are forced low while reset is held.
  assign stall        = hold && !RESET;
  assign O_FU_STALL   = stall;
  assign O_FU_BUBBLE  = stall;
  assign O_FU_MC_BUSY = |pend;

  // Scoreboard update: completion clears first, then a non-stalled issue sets.
  always_comb begin
    pend_nxt = pend;
    if (I_FU_MC_DONE)                pend_nxt[I_FU_MC_DONE_regDst] = 1'b0;
    if (I_FU_MC_ISSUE && !stall)     pend_nxt[I_FU_MC_regDst]      = 1'b1;
    pend_nxt[REG_ZERO] = 1'b0;
  end

  // State, counter and scoreboard registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
    end
  end

`ifdef FU_PERF_CNT_EN
  // Saturating counters: stalled cycles and fresh load-use detections.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      O_FU_STALL_CYCLES <= '0;
      O_FU_LU_EVENTS    <= '0;
    end else begin
      if (stall && (O_FU_STALL_CYCLES != '1)) begin
        O_FU_STALL_CYCLES <= O_FU_STALL_CYCLES + PERF_W'(1);
      end
      if ((state == IDLE) && lu && (O_FU_LU_EVENTS != '1)) begin
        O_FU_LU_EVENTS <= O_FU_LU_EVENTS + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: LOAD_STALL=1 and LOAD_STALL=3 instances share stimulus.
module tb_fwd_hazard_unit;

  localparam int unsigned W  = 5;
  localparam int unsigned NS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NS*W-1:0] exe_src, id_src;
  logic [W-1:0]    exe_dst, mem_dst, wb_dst, id_dst, mc_dst, done_dst;
  logic            exe_wr, exe_rd, mem_wr, wb_wr, id_wr, id_mc, issue, done;
  logic [NS-1:0]   id_valid;

  logic [2*NS-1:0] sel [2];
  logic            stall [2];
  logic            bubble [2];
  logic            busy [2];
`ifdef FU_PERF_CNT_EN
  logic [31:0]     stc [2];
  logic [31:0]     lue [2];
`endif

  fwd_hazard_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .LOAD_STALL(1)) u_dut_ls1 (
    .CLK(clk), .RESET(rst),
    .I_FU_EXE_SRC(exe_src), .I_FU_EXE_regDst(exe_dst),
    .I_FU_EXE_RegWrite(exe_wr), .I_FU_EXE_MemRead(exe_rd),
    .I_FU_MEM_regDst(mem_dst), .I_FU_MEM_RegWrite(mem_wr),
    .I_FU_WB_regDst(wb_dst), .I_FU_WB_RegWrite(wb_wr),
    .I_FU_ID_SRC(id_src), .I_FU_ID_SRC_VALID(id_valid),
    .I_FU_ID_regDst(id_dst), .I_FU_ID_RegWrite(id_wr), .I_FU_ID_IS_MC(id_mc),
    .I_FU_MC_ISSUE(issue), .I_FU_MC_regDst(mc_dst),
    .I_FU_MC_DONE(done), .I_FU_MC_DONE_regDst(done_dst),
    .O_FU_FWD_SEL(sel[0]), .O_FU_STALL(stall[0]), .O_FU_BUBBLE(bubble[0]),
    .O_FU_MC_BUSY(busy[0])
`ifdef FU_PERF_CNT_EN
    , .O_FU_STALL_CYCLES(stc[0]), .O_FU_LU_EVENTS(lue[0])
`endif
  );

  fwd_hazard_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .LOAD_STALL(3)) u_dut_ls3 (
    .CLK(clk), .RESET(rst),
    .I_FU_EXE_SRC(exe_src), .I_FU_EXE_regDst(exe_dst),
    .I_FU_EXE_RegWrite(exe_wr), .I_FU_EXE_MemRead(exe_rd),
    .I_FU_MEM_regDst(mem_dst), .I_FU_MEM_RegWrite(mem_wr),
    .I_FU_WB_regDst(wb_dst), .I_FU_WB_RegWrite(wb_wr),
    .I_FU_ID_SRC(id_src), .I_FU_ID_SRC_VALID(id_valid),
    .I_FU_ID_regDst(id_dst), .I_FU_ID_RegWrite(id_wr), .I_FU_ID_IS_MC(id_mc),
    .I_FU_MC_ISSUE(issue), .I_FU_MC_regDst(mc_dst),
    .I_FU_MC_DONE(done), .I_FU_MC_DONE_regDst(done_dst),
    .O_FU_FWD_SEL(sel[1]), .O_FU_STALL(stall[1]), .O_FU_BUBBLE(bubble[1]),
    .O_FU_MC_BUSY(busy[1])
`ifdef FU_PERF_CNT_EN
    , .O_FU_STALL_CYCLES(stc[1]), .O_FU_LU_EVENTS(lue[1])
`endif
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state: pending set, remaining forced hold cycles, event counts.
  bit          mp [2][32];
  int          hold_m [2];
  int          ls_m [2] = '{1, 3};
  int unsigned stc_m [2];
  int unsigned lue_m [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*NS-1:0] m_fwd();
    logic [2*NS-1:0] r = '0;
    for (int k = 0; k < NS; k++) begin
      if (mem_wr && mem_dst != 0 && mem_dst == exe_src[k*W +: W])   r[2*k +: 2] = 2'b10;
      else if (wb_wr && wb_dst != 0 && wb_dst == exe_src[k*W +: W]) r[2*k +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic bit m_lu();
    bit hit = 0;
    for (int k = 0; k < NS; k++)
      if (id_valid[k] && id_src[k*W +: W] == exe_dst) hit = 1;
    return hit && exe_rd && exe_wr && exe_dst != 0;
  endfunction

  function automatic bit m_busy(input int i);
    bit b = 0;
    for (int r = 0; r < 32; r++) if (mp[i][r]) b = 1;
    return b;
  endfunction

  function automatic bit m_sb(input int i);
    bit h = 0;
    for (int k = 0; k < NS; k++)
      if (id_valid[k] && mp[i][id_src[k*W +: W]]) h = 1;
    if (id_wr && mp[i][id_dst]) h = 1;
    if (id_mc && m_busy(i)) h = 1;
    return h;
  endfunction

  function automatic bit m_stall(input int i);
    if (rst) return 0;
    return (hold_m[i] > 0) || m_lu() || m_sb(i);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) mp[i][r] = 0;
      hold_m[i] = 0;
      stc_m[i]  = 0;
      lue_m[i]  = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("fwd_sel%0d", i), 64'(sel[i]), 64'(m_fwd()));
      chk($sformatf("stall%0d", i), 64'(stall[i]), 64'(m_stall(i)));
      chk($sformatf("bubble%0d", i), 64'(bubble[i]), 64'(m_stall(i)));
      chk($sformatf("busy%0d", i), 64'(busy[i]), 64'(m_busy(i)));
`ifdef FU_PERF_CNT_EN
      chk($sformatf("stall_cycles%0d", i), 64'(stc[i]), 64'(stc_m[i]));
      chk($sformatf("lu_events%0d", i), 64'(lue[i]), 64'(lue_m[i]));
`endif
    end
  endtask

  task automatic model_step();
    bit s, lu;
    if (rst) begin
      m_reset();
      return;
    end
    lu = m_lu();
    for (int i = 0; i < 2; i++) begin
      s = m_stall(i);
      if (s) stc_m[i]++;
      if (hold_m[i] == 0 && lu) lue_m[i]++;
      if (hold_m[i] > 0) hold_m[i]--;
      else if (lu)       hold_m[i] = ls_m[i] - 1;
      if (done) mp[i][done_dst] = 0;
      if (issue && !s) mp[i][mc_dst] = 1;
      mp[i][0] = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exe_src = '0; exe_dst = '0; exe_wr = 0; exe_rd = 0;
    mem_dst = '0; mem_wr = 0; wb_dst = '0; wb_wr = 0;
    id_src = '0; id_valid = '0; id_dst = '0; id_wr = 0; id_mc = 0;
    issue = 0; mc_dst = '0; done = 0; done_dst = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    m_reset();
    #1;
    cycle();
    cycle();
    rst = 0;

    // Forwarding priority on channel 0.
    exe_src[0 +: W] = 5'd3; mem_dst = 5'd3; mem_wr = 1; wb_dst = 5'd3; wb_wr = 1;
    #1; chk("tp_fwd_mem", 64'(sel[0][1:0]), 64'(2'b10)); cycle();
    mem_wr = 0;
    #1; chk("tp_fwd_wb", 64'(sel[0][1:0]), 64'(2'b01)); cycle();
    mem_wr = 1; mem_dst = 5'd0; wb_dst = 5'd0;
    #1; chk("tp_fwd_rf", 64'(sel[0][1:0]), 64'(2'b00)); cycle();

    // Load-use: 1 cycle for LOAD_STALL=1, 3 cycles for LOAD_STALL=3.
    exe_rd = 1; exe_wr = 1; exe_dst = 5'd5; id_src[W +: W] = 5'd5; id_valid = 2'b10;
    #1; chk("tp_lu_ls1", 64'(stall[0]), 64'd1); chk("tp_lu_ls3", 64'(stall[1]), 64'd1); cycle();
    exe_rd = 0;
    #1; chk("tp_lu_ls1_end", 64'(stall[0]), 64'd0); chk("tp_lu_ls3_h1", 64'(stall[1]), 64'd1); cycle();
    #1; chk("tp_lu_ls3_h2", 64'(bubble[1]), 64'd1); cycle();
    #1; chk("tp_lu_ls3_end", 64'(stall[1]), 64'd0); cycle();

    // No stall with the channel invalid or a load into r0.
    exe_rd = 1; id_valid = 2'b01;
    #1; chk("tp_lu_invalid", 64'(stall[1]), 64'd0); cycle();
    id_valid = 2'b10; exe_dst = 5'd0; id_src[W +: W] = 5'd0;
    #1; chk("tp_lu_r0", 64'(stall[1]), 64'd0); cycle();
    clear_inputs();

    // Scoreboard RAW until the cycle after DONE.
    issue = 1; mc_dst = 5'd8; cycle();
    issue = 0; id_src[0 +: W] = 5'd8; id_valid = 2'b01;
    #1; chk("tp_sb_busy", 64'(busy[0]), 64'd1); chk("tp_sb_raw", 64'(stall[0]), 64'd1); cycle();
    done = 1; done_dst = 5'd8;
    #1; chk("tp_sb_done_cyc", 64'(stall[0]), 64'd1); cycle();
    done = 0;
    #1; chk("tp_sb_clear", 64'(stall[0]), 64'd0); chk("tp_sb_idle", 64'(busy[1]), 64'd0); cycle();

    // DONE and ISSUE on the same register keep it pending; structural stall.
    id_valid = '0; issue = 1; mc_dst = 5'd8; cycle();
    done = 1; done_dst = 5'd8; cycle();
    issue = 0; done = 0;
    #1; chk("tp_sb_same_reg", 64'(busy[0]), 64'd1); cycle();
    id_mc = 1;
    #1; chk("tp_sb_struct", 64'(stall[1]), 64'd1); cycle();
    id_mc = 0;

    // Reset in the middle of the LOAD_STALL=3 hold with register 8 pending.
    exe_rd = 1; exe_wr = 1; exe_dst = 5'd5; id_src = {5'd5, 5'd1}; id_valid = 2'b10;
    cycle();
    exe_rd = 0;
    #1; chk("tp_rst_pre_hold", 64'(stall[1]), 64'd1);
    rst = 1; m_reset();
    #1;
    chk("tp_rst_stall", 64'(stall[1]), 64'd0);
    chk("tp_rst_bubble", 64'(bubble[1]), 64'd0);
    chk("tp_rst_busy", 64'(busy[1]), 64'd0);
`ifdef FU_PERF_CNT_EN
    chk("tp_rst_stc", 64'(stc[1]), 64'd0);
    chk("tp_rst_lue", 64'(lue[1]), 64'd0);
`endif
    cycle();
    rst = 0;
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (rst) m_reset();
      for (int k = 0; k < NS; k++) begin
        exe_src[k*W +: W] = W'($urandom_range(0, 7));
        id_src[k*W +: W]  = W'($urandom_range(0, 7));
      end
      exe_dst  = W'($urandom_range(0, 7));
      mem_dst  = W'($urandom_range(0, 7));
      wb_dst   = W'($urandom_range(0, 7));
      id_dst   = W'($urandom_range(0, 7));
      exe_wr   = 1'($urandom_range(0, 1));
      exe_rd   = ($urandom_range(0, 3) == 0);
      mem_wr   = 1'($urandom_range(0, 1));
      wb_wr    = 1'($urandom_range(0, 1));
      id_valid = NS'($urandom_range(0, 3));
      id_wr    = 1'($urandom_range(0, 1));
      id_mc    = ($urandom_range(0, 7) == 0);
      done     = ($urandom_range(0, 2) == 0);
      done_dst = W'($urandom_range(0, 7));
      mc_dst   = W'($urandom_range(0, 7));
      issue    = 0;
      if (!m_stall(0) && !m_stall(1)) issue = ($urandom_range(0, 3) == 0);
      cycle();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
